// File: rtl/qspi_mem_responder.sv
// Quad-SPI target memory model: byte RAM behind commands 0xEB (quad read) and 0x38 (quad write), plus a host backdoor port.
// Define QSPI_RESP_ERR_EN to add the sticky err_o protocol-error flag.
module qspi_mem_responder #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DUMMY = 4,
    parameter int unsigned SYNC  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs_n_i,
    input  logic          sck_i,
    input  logic [3:0]    sd_i,
    output logic [3:0]    sd_o,
    output logic [3:0]    sd_oen_o,
    output logic          busy_o,
    input  logic [AW-1:0] bd_addr_i,
    input  logic          bd_we_i,
    input  logic [7:0]    bd_wdata_i,
    output logic [7:0]    bd_rdata_o
`ifdef QSPI_RESP_ERR_EN
    ,
    output logic          err_o
`endif
);

    localparam logic [7:0]  CMD_QREAD  = 8'hEB;
    localparam logic [7:0]  CMD_QWRITE = 8'h38;
    localparam int unsigned CW = ($clog2(DUMMY + 1) > 3) ? $clog2(DUMMY + 1) : 3;

    if (DUMMY < 1) begin : g_dummy_check
        $error("qspi_mem_responder: DUMMY must be at least 1");
    end
    if (SYNC < 1) begin : g_sync_check
        $error("qspi_mem_responder: SYNC must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD,
        ST_WR,
        ST_IGN
    } state_t;

    logic [SYNC-1:0] r_cs_sync;
    logic [SYNC-1:0] r_sck_sync;
    logic [3:0]      r_sd_sync [SYNC];
    logic            r_cs_q;
    logic            r_sck_q;

    logic            w_cs_s;
    logic            w_sck_s;
    logic [3:0]      w_sd;
    logic            w_rise;
    logic            w_fall;
    logic            w_cs_fall;
    logic            w_cs_rise;
    logic [7:0]      w_cmd;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_byte;
    logic [AW-1:0]   r_addr;
    logic            r_is_rd;
    logic            r_we;
    logic [3:0]      r_sd_o;
    logic            r_oen;

    logic [7:0]      r_mem [2**AW];
    logic [7:0]      r_mem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cs_sync  <= '1;
            r_sck_sync <= '0;
            r_cs_q     <= 1'b1;
            r_sck_q    <= 1'b0;
            for (int unsigned i = 0; i < SYNC; i++) begin
                r_sd_sync[i] <= '0;
            end
        end else begin
            r_cs_sync    <= SYNC'({r_cs_sync, cs_n_i});
            r_sck_sync   <= SYNC'({r_sck_sync, sck_i});
            r_sd_sync[0] <= sd_i;
            for (int unsigned i = 1; i < SYNC; i++) begin
                r_sd_sync[i] <= r_sd_sync[i-1];
            end
            r_cs_q  <= w_cs_s;
            r_sck_q <= w_sck_s;
        end
    end

    assign w_cs_s    = r_cs_sync[SYNC-1];
    assign w_sck_s   = r_sck_sync[SYNC-1];
    assign w_sd      = r_sd_sync[SYNC-1];
    assign w_rise    = w_sck_s & ~r_sck_q;
    assign w_fall    = ~w_sck_s & r_sck_q;
    assign w_cs_fall = ~w_cs_s & r_cs_q;
    assign w_cs_rise = w_cs_s & ~r_cs_q;
    assign w_cmd     = {r_byte[3:0], w_sd};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_addr  <= '0;
            r_is_rd <= 1'b0;
            r_we    <= 1'b0;
            r_sd_o  <= '0;
            r_oen   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // A completed write byte lands one cycle after its second rise, then the address steps.
            if (r_we) begin
                r_addr <= r_addr + AW'(1);
            end
            if (w_cs_rise && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_oen   <= 1'b0;
                r_sd_o  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= ST_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_byte <= w_cmd;
                            if (r_cnt[0]) begin
                                r_cnt <= '0;
                                if (w_cmd == CMD_QREAD) begin
                                    r_is_rd <= 1'b1;
                                    r_state <= ST_ADDR;
                                end else if (w_cmd == CMD_QWRITE) begin
                                    r_is_rd <= 1'b0;
                                    r_state <= ST_ADDR;
                                end else begin
                                    r_state <= ST_IGN;
                                end
                            end else begin
                                r_cnt <= CW'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            // Only the low AW bits of the 24-bit address survive the shift.
                            r_addr <= AW'({r_addr, w_sd});
                            if (r_cnt == CW'(5)) begin
                                r_cnt   <= '0;
                                r_state <= r_is_rd ? ST_DUMMY : ST_WR;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == CW'(DUMMY - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_RD;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    ST_RD: begin
                        if (w_fall) begin
                            r_oen  <= 1'b1;
                            r_sd_o <= r_cnt[0] ? r_mem_q[3:0] : r_mem_q[7:4];
                            if (r_cnt[0]) begin
                                r_cnt  <= '0;
                                r_addr <= r_addr + AW'(1);
                            end else begin
                                r_cnt <= CW'(1);
                            end
                        end
                    end
                    ST_WR: begin
                        if (w_rise) begin
                            r_byte <= w_cmd;
                            if (r_cnt[0]) begin
                                r_cnt <= '0;
                                r_we  <= 1'b1;
                            end else begin
                                r_cnt <= CW'(1);
                            end
                        end
                    end
                    ST_IGN: begin
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Bus read port tracks r_addr continuously, so the next byte is ready long before the following fall.
    always_ff @(posedge clk_i) begin
        if (r_we) begin
            r_mem[r_addr] <= r_byte;
        end else if (bd_we_i) begin
            r_mem[bd_addr_i] <= bd_wdata_i;
        end
        r_mem_q <= r_mem[r_addr];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bd_rdata_o <= '0;
        end else begin
            bd_rdata_o <= r_mem[bd_addr_i];
        end
    end

    assign sd_o     = r_sd_o;
    assign sd_oen_o = {4{r_oen}};
    assign busy_o   = (r_state != ST_IDLE);

`ifdef QSPI_RESP_ERR_EN
    logic [1:0] r_gap;
    logic       r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gap <= 2'd3;
            r_err <= 1'b0;
        end else begin
            if (w_fall) begin
                r_gap <= 2'd1;
            end else if (r_gap != 2'd3) begin
                r_gap <= r_gap + 2'd1;
            end
            if (w_rise && (r_gap != 2'd3)) begin
                r_err <= 1'b1;
            end
            if (!w_cs_rise && (r_state == ST_CMD) && w_rise && r_cnt[0] &&
                (w_cmd != CMD_QREAD) && (w_cmd != CMD_QWRITE)) begin
                r_err <= 1'b1;
            end
            if (w_cs_rise && (((r_state == ST_CMD) && (r_cnt != '0)) ||
                              (r_state == ST_ADDR) ||
                              ((r_state == ST_WR) && r_cnt[0]))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: drives the quad-SPI bus as an initiator and checks against hand-computed values.
module tb_qspi_mem_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned DUMMY = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned H     = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic          sck;
    logic [3:0]    sd_in;
    logic [3:0]    sd_out;
    logic [3:0]    oen;
    logic          busy;
    logic [AW-1:0] bd_addr;
    logic          bd_we;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;
`ifdef QSPI_RESP_ERR_EN
    logic          err;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    qspi_mem_responder #(
        .AW   (AW),
        .DUMMY(DUMMY),
        .SYNC (SYNC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cs_n_i    (cs_n),
        .sck_i     (sck),
        .sd_i      (sd_in),
        .sd_o      (sd_out),
        .sd_oen_o  (oen),
        .busy_o    (busy),
        .bd_addr_i (bd_addr),
        .bd_we_i   (bd_we),
        .bd_wdata_i(bd_wdata),
        .bd_rdata_o(bd_rdata)
`ifdef QSPI_RESP_ERR_EN
        ,
        .err_o     (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] rd, output logic [3:0] en);
        sd_in = nib;
        repeat (H) @(negedge clk);
        rd  = sd_out;
        en  = oen;
        sck = 1'b1;
        repeat (H) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] rd, en;
        sck_cycle(b[7:4], rd, en);
        sck_cycle(b[3:0], rd, en);
    endtask

    task automatic start_txn(input logic [7:0] cmd, input logic [23:0] a);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        send_byte(cmd);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic end_txn(input string tag);
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_oen_drop"}, oen, 0);
        repeat (H) @(negedge clk);
    endtask

    task automatic qspi_read(input logic [23:0] a, input logic [15:0] exp, input string tag);
        logic [3:0] rd, en;
        start_txn(8'hEB, a);
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < int'(DUMMY); i++) begin
            sck_cycle(4'h0, rd, en);
            check($sformatf("%s_dummy%0d_oen", tag, i), en, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            sck_cycle(4'h0, rd, en);
            check($sformatf("%s_nib%0d", tag, i), rd, exp[15-4*i -: 4]);
            check($sformatf("%s_nib%0d_oen", tag, i), en, 4'hF);
        end
        end_txn(tag);
    endtask

    task automatic qspi_write(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1, input string tag);
        start_txn(8'h38, a);
        send_byte(b0);
        send_byte(b1);
        end_txn(tag);
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        @(negedge clk);
        bd_we    = 1'b0;
    endtask

    task automatic bd_check(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        bd_addr = a;
        @(negedge clk);
        check(tag, bd_rdata, exp);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rd, en, en_or;
        rst      = 1'b1;
        cs_n     = 1'b1;
        sck      = 1'b0;
        sd_in    = 4'h0;
        bd_addr  = '0;
        bd_we    = 1'b0;
        bd_wdata = '0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_oen", oen, 0);
        check("rst_sd_o", sd_out, 0);
        check("rst_bd_rdata", bd_rdata, 0);
`ifdef QSPI_RESP_ERR_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Backdoor preload, bus read.
        bd_write(12'h010, 8'hA5);
        bd_write(12'h011, 8'h3C);
        qspi_read(24'h000010, 16'hA53C, "rd1");

        // Bus write, backdoor read.
        qspi_write(24'h000100, 8'hDE, 8'hAD, "wr1");
        bd_check("wr1_bd100", 12'h100, 8'hDE);
        bd_check("wr1_bd101", 12'h101, 8'hAD);

        // Wrap-around at the top of the array.
        bd_write(12'hFFF, 8'h81);
        bd_write(12'h000, 8'h42);
        qspi_read(24'h000FFF, 16'h8142, "wrap");

        // Unknown command is ignored.
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        send_byte(8'h9F);
        en_or = 4'h0;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'h5, rd, en);
            en_or = en_or | en;
        end
        check("unk_oen", en_or, 4'h0);
        end_txn("unk");
        bd_check("unk_bd010", 12'h010, 8'hA5);
        bd_check("unk_bd100", 12'h100, 8'hDE);
        bd_check("unk_bd101", 12'h101, 8'hAD);
`ifdef QSPI_RESP_ERR_EN
        check("unk_err", err, 1);
        reset_pulse();
        check("err_cleared", err, 0);
`endif

        // Abort mid-write discards the partial byte.
        bd_write(12'h020, 8'h11);
        bd_write(12'h021, 8'h22);
        start_txn(8'h38, 24'h000020);
        sck_cycle(4'h7, rd, en);
        end_txn("abort");
        bd_check("abort_bd020", 12'h020, 8'h11);
`ifdef QSPI_RESP_ERR_EN
        check("abort_err", err, 1);
        reset_pulse();
`endif
        qspi_read(24'h000020, 16'h1122, "after_abort");

        // Reset during the data phase of a read.
        start_txn(8'hEB, 24'h000010);
        for (int i = 0; i < int'(DUMMY); i++) begin
            sck_cycle(4'h0, rd, en);
        end
        sck_cycle(4'h0, rd, en);
        check("rstrd_nib0", rd, 4'hA);
        sck_cycle(4'h0, rd, en);
        check("rstrd_nib1", rd, 4'h5);
        check("rstrd_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstrd_oen", oen, 0);
        check("rstrd_busy", busy, 0);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bd_check("rstrd_bd010", 12'h010, 8'hA5);
        bd_check("rstrd_bd011", 12'h011, 8'h3C);
        bd_check("rstrd_bd100", 12'h100, 8'hDE);
        bd_check("rstrd_bdFFF", 12'hFFF, 8'h81);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Target-side QSPI memory model. It is the responder for the quad-SPI bus driven by the exotiny memory interface (cs_n, sck, sd[3:0]).
- Emulates a byte-addressed quad RAM/ROM with an internal array, so the SoC can be exercised in simulation and FPGA bring-up without external PSRAM or flash.
- sck, cs_n and sd are oversampled by clk_i. The internal array has a host backdoor port for preload and inspection.

Parameters:
- AW, 12, internal array address width in bytes. The 24-bit bus address is truncated to AW LSBs.
- DUMMY, 4, number of sck cycles between the last address nibble and the first read data nibble.
- SYNC, 2, synchronizer depth on cs_n_i, sck_i and sd_i.

Ports:
- clk_i  in  1  system clock. Must be at least 4x the sck frequency.
- rst_i  in  1  synchronous reset, active high.
- cs_n_i  in  1  chip select from initiator, active low.
- sck_i  in  1  serial clock from initiator, SPI mode 0.
- sd_i  in  4  quad data from initiator.
- sd_o  out  4  quad data to initiator.
- sd_oen_o  out  4  output enable for sd_o, active high, all bits equal.
- busy_o  out  1  high while a transaction is in progress (state != IDLE).
- bd_addr_i  in  AW  backdoor byte address.
- bd_we_i  in  1  backdoor write strobe.
- bd_wdata_i  in  8  backdoor write data.
- bd_rdata_o  out  8  backdoor read data, registered, 1-cycle latency.

Behaviour:
- Reset: all outputs 0, state IDLE. The array contents are not reset.
- Synchronization: cs_n, sck and sd pass through SYNC flops.
  - rise = sck_s & ~sck_q; fall = ~sck_s & sck_q.
  - All sampling uses the synchronized signals.
- Nibble timing:
  - sd is sampled on rise.
  - sd_o is updated on the clk_i cycle after fall.
  - Nibble order is high nibble first, all 4 lines per sck.
- States: IDLE -> CMD -> ADDR -> (DUMMY -> RD) | WR, plus IGN.
  - IDLE: on cs_n falling (sync), go to CMD and clear the nibble counter.
  - CMD: 2 rises assemble the command byte.
    - 0xEB (quad read) -> ADDR.
    - 0x38 (quad write) -> ADDR.
    - Any other value -> IGN.
  - ADDR: 6 rises assemble a 24-bit address, MSB nibble first. Then go to DUMMY for a read or WR for a write.
  - DUMMY: count DUMMY rises.
    - The array read is issued during dummy.
    - DUMMY=0 is illegal (the elaboration check fails).
    - After the last dummy rise, go to RD.
    - sd_oen_o asserts on the following fall together with the first data nibble.
  - RD: on each fall, drive the next nibble.
    - After the low nibble, the address increments and the next byte is prefetched; it must be ready before the next fall.
    - Reads stream indefinitely.
  - WR: 2 rises form a byte.
    - The byte is written to array[addr] on the cycle after the second rise, then the address increments.
    - A backdoor write in the same cycle loses to the bus write.
  - IGN: no output; wait for cs_n high.
- Address wrap: the address increments modulo 2^AW. Byte 0 follows byte 2^AW-1.
- cs_n rising in any state:
  - Go to IDLE next cycle; sd_oen_o = 0 in that same cycle.
  - A partially received write byte is discarded.
  - A partial command or address is discarded.
- sd_oen_o is 0 in every state except RD.
- Backdoor: bd_rdata_o = array[bd_addr_i] registered. It is usable at any time.

Optional Feature:
- Macro: QSPI_RESP_ERR_EN.
- With the macro defined:
  - Adds port err_o (out, 1), a sticky error flag cleared only by rst_i.
  - err_o sets on an unknown command byte.
  - err_o sets on cs_n rising with a partial nibble count in CMD, ADDR or WR (odd nibble count or address incomplete).
  - err_o sets when sck rises within 2 clk_i cycles after a fall (oversampling violation).
- Without the macro: no err_o port. These conditions are handled silently as described in Behaviour.

Test Plan:
- Backdoor preload, bus read:
  - Stimulus: backdoor write 0xA5 to 0x010 and 0x3C to 0x011; bus sends 0xEB, address 0x000010, 4 dummy cycles, then 4 sck cycles.
  - Response: sd_o nibbles A,5,3,C; sd_oen_o = 0xF only during data.
- Bus write, backdoor read:
  - Stimulus: bus sends 0x38, address 0x000100, data 0xDE 0xAD.
  - Response: backdoor read of 0x100 gives 0xDE and 0x101 gives 0xAD; busy_o drops within SYNC+1 cycles of cs_n high.
- Wrap-around:
  - Stimulus: with AW=12, read starting at 0x000FFF for 2 bytes.
  - Response: bytes returned are array[0xFFF] then array[0x000].
- Unknown command:
  - Stimulus: bus sends command 0x9F followed by 8 sck cycles.
  - Response: sd_oen_o stays 0; array unchanged; with QSPI_RESP_ERR_EN, err_o = 1.
- Abort mid-write:
  - Stimulus: 0x38, address 0x000020, one data nibble 0x7, then cs_n high.
  - Response: array[0x020] unchanged; state IDLE; the next 0xEB read works normally.
- Reset mid-read:
  - Stimulus: assert rst_i during RD.
  - Response: sd_oen_o = 0 and busy_o = 0 the next cycle; backdoor shows array contents intact.
